// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA scan-out path.
// Optional VGA_SCANOUT_BORDER_EN adds a border flag to the pipeline flags.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int FB_ADDR_W = 19;
    localparam int FB_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    // Per-pixel control that rides alongside the frame-buffer read latency.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic fstart;
`ifdef VGA_SCANOUT_BORDER_EN
        logic border;
`endif
    } vid_flags_t;

    function automatic vid_flags_t idle_flags();
        vid_flags_t f;
        f       = '0;
        f.hsync = 1'b1;
        f.vsync = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with sync, active and frame strobes.
// With VGA_SCANOUT_BORDER_EN defined it also flags the outermost active pixels.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
)
(
    input  logic clk,
    input  logic rst_n,
    output logic active_c,
    output logic hsync_c,
    output logic vsync_c,
    output logic fstart_c,
    output logic flip_c
`ifdef VGA_SCANOUT_BORDER_EN
    ,
    output logic border_c
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Next-state for the raster counters; v advances when h wraps.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Counter-stage decode; flip_c marks the first line of vertical blank.
    always_comb begin
        active_c = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_c  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vsync_c  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        fstart_c = (h_q == '0) && (v_q == '0);
        flip_c   = (h_q == '0) && (v_q == V_ACT);
`ifdef VGA_SCANOUT_BORDER_EN
        border_c = active_c && ((h_q == '0) || (h_q == H_ACT - 1'b1) ||
                                (v_q == '0) || (v_q == V_ACT - 1'b1));
`endif
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: frame-buffer reads, tear-free bank flip in vblank, pin alignment.
// Optional VGA_SCANOUT_BORDER_EN forces a white border on the outer active pixels.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int RD_LATENCY = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 swap,
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [FB_ADDR_W-1:0] rd_addr,
    input  logic [8:0]           rd_data,
    output logic [2:0]           vga_r,
    output logic [2:0]           vga_g,
    output logic [2:0]           vga_b,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 front_bank,
    output logic                 frame_start
);

    logic active_s, hsync_s, vsync_s, fstart_s, flip_s;
`ifdef VGA_SCANOUT_BORDER_EN
    logic border_s;
`endif
    vid_flags_t cnt_flags_s;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .active_c (active_s),
        .hsync_c  (hsync_s),
        .vsync_c  (vsync_s),
        .fstart_c (fstart_s),
        .flip_c   (flip_s)
`ifdef VGA_SCANOUT_BORDER_EN
        ,
        .border_c (border_s)
`endif
    );

    logic                 swap_meta_q, swap_sync_q, swap_prev_q;
    logic                 swap_edge_s;
    logic                 pending_q, pending_d;
    logic                 front_q, front_d;
    logic                 rd_en_q, rd_en_d;
    logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    vid_flags_t           pipe_q [0:RD_LATENCY];
    vid_flags_t           pipe_d [0:RD_LATENCY];
    vid_flags_t           tail_s;
    rgb333_t              pix_s;
    rgb333_t              rgb_q, rgb_d;
    logic                 hsync_q, hsync_d, vsync_q, vsync_d, fstart_q, fstart_d;

    // Bundle counter-stage flags for the alignment shift register.
    always_comb begin
        cnt_flags_s        = idle_flags();
        cnt_flags_s.active = active_s;
        cnt_flags_s.hsync  = hsync_s;
        cnt_flags_s.vsync  = vsync_s;
        cnt_flags_s.fstart = fstart_s;
`ifdef VGA_SCANOUT_BORDER_EN
        cnt_flags_s.border = border_s;
`endif
    end

    // Address counter stands in for y*H_ACTIVE+x; swaps coalesce until the flip point.
    always_comb begin
        swap_edge_s = swap_sync_q ^ swap_prev_q;
        rd_en_d     = active_s;
        if (fstart_s) begin
            rd_addr_d = '0;
        end else if (active_s) begin
            rd_addr_d = rd_addr_q + 19'd1;
        end else begin
            rd_addr_d = rd_addr_q;
        end
        if (flip_s) begin
            pending_d = 1'b0;
            if (pending_q || swap_edge_s) begin
                front_d = ~front_q;
            end else begin
                front_d = front_q;
            end
        end else begin
            pending_d = pending_q | swap_edge_s;
            front_d   = front_q;
        end
    end

    // Flags are delayed so they meet rd_data; the tail drives the pin registers.
    always_comb begin
        pipe_d[0] = cnt_flags_s;
        for (int i = 1; i <= RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        tail_s = pipe_q[RD_LATENCY];
        pix_s  = rgb333_t'(rd_data);
`ifdef VGA_SCANOUT_BORDER_EN
        if (tail_s.border) begin
            pix_s = rgb333_t'(9'h1FF);
        end else begin
            pix_s = rgb333_t'(rd_data);
        end
`endif
        if (tail_s.active) begin
            rgb_d = pix_s;
        end else begin
            rgb_d = rgb333_t'(9'h000);
        end
        hsync_d  = tail_s.hsync;
        vsync_d  = tail_s.vsync;
        fstart_d = tail_s.fstart;
    end

    // Swap synchroniser, bank state, read request and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_meta_q <= 1'b0;
            swap_sync_q <= 1'b0;
            swap_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            front_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                pipe_q[i] <= idle_flags();
            end
            rgb_q       <= rgb333_t'(9'h000);
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            fstart_q    <= 1'b0;
        end else begin
            swap_meta_q <= swap;
            swap_sync_q <= swap_meta_q;
            swap_prev_q <= swap_sync_q;
            pending_q   <= pending_d;
            front_q     <= front_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pipe_q      <= pipe_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            fstart_q    <= fstart_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign rd_bank     = front_q;
    assign front_bank  = front_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fstart_q;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer of the double-buffered RGB333 frame buffer that the test-pattern and draw stages write into. Generates 640×480@60 VGA timing from the pixel clock and issues one read per active pixel to the front buffer. Aligns returned data with the sync signals and drives the VGA pins. Tracks the writer's `swap` toggle and flips the front/back buffer only during vertical blank, so a frame is never torn.

## Interface
Parameters:
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `RD_LATENCY` 1: clocks from `rd_en`/`rd_addr` to valid `rd_data`; legal range 1–4.

Ports:
- `clk` in 1: pixel clock, one pixel per cycle.
- `rst_n` in 1: asynchronous, active-low reset.
- `swap` in 1: toggle from the writer; every level change requests one buffer flip.
- `rd_en` out 1: read strobe to the frame buffer.
- `rd_bank` out 1: bank being read; equals `front_bank`.
- `rd_addr` out 19: pixel index within the bank, range 0..307199.
- `rd_data` in 9: RGB333 data as {r[2:0], g[2:0], b[2:0]}.
- `vga_r`, `vga_g`, `vga_b` out 3 each: colour outputs.
- `hsync`, `vsync` out 1: active-low sync outputs.
- `front_bank` out 1: bank currently being displayed; the writer targets `~front_bank`.
- `frame_start` out 1: one-cycle pulse when the first active pixel reaches the pins.

## Operation
- Counters:
  - `h` runs 0..799 and wraps to 0.
  - `v` increments when `h` wraps, runs 0..524, and wraps to 0.
  - Active region is `h<640 && v<480`.
- Sync decode at the counter stage:
  - `hsync_c` = 0 for `h` in 656..751.
  - `vsync_c` = 0 for `v` in 490..491.
- Read address: a running 19-bit counter replaces the `y*640+x` multiplier.
  - Increments on each active pixel.
  - Clears to 0 at `h=0,v=0`.
- Swap tracking:
  - `swap` passes through a 2-flop synchroniser.
  - A change between successive synchronised samples sets `pending`.
  - Any number of changes within one frame coalesce into a single flip.
- Flip point is the counter state `h=0,v=480`, the first blank line. If `pending` is set there, `front_bank` toggles and `pending` clears.
  - A swap edge detected in that same cycle also causes the flip; `pending` stays clear.
  - An edge detected after that cycle is held until the next frame.
- Blanking: whenever the delayed active flag is 0, `vga_r/g/b` output 0 and `rd_data` is ignored.

## Timing
- Reset values:
  - `rd_en`=0, `rd_addr`=0, `rd_bank`=0, `front_bank`=0.
  - `vga_r/g/b`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
  - `h`=`v`=0, `pending`=0, synchroniser flops=0.
- Pipeline, for a counter state at cycle c:
  - `rd_en`/`rd_addr` are registered at c+1.
  - `rd_data` is valid at c+1+`RD_LATENCY`.
  - Pins are registered at c+2+`RD_LATENCY`.
- Total pin latency is 2+`RD_LATENCY` cycles (3 at default).
- `hsync_c`, `vsync_c`, the active flag and the frame-start flag travel through a matching shift register, so all pins change in the same cycle.
- `rd_en`=1 exactly for the 307200 active cycles per frame. `rd_addr` holds its last value while `rd_en`=0.
- `front_bank` changes at c+1 after the flip point. Reads issued for frame N+1 all use the new bank.
- Swap latency: an edge that reaches the synchroniser output before `h=0,v=480` is displayed from the next `frame_start`.
- Reset asserted mid-frame:
  - All state returns to reset values immediately.
  - After release, scan resumes at `h=0,v=0` on the first clock.
  - The first `frame_start` arrives 2+`RD_LATENCY` cycles after release.

## Configuration
- `VGA_SCANOUT_BORDER_EN` defined: on active pixels with `x∈{0,639}` or `y∈{0,479}`, the pins output 3'b111 on all channels, overriding `rd_data`. This is a bring-up aid.
- `VGA_SCANOUT_BORDER_EN` undefined: pixel data comes solely from `rd_data`, with no border logic.
- Timing and handshakes are identical in both builds.

## Structure
- Package `vga_pkg` holds:
  - the `rgb333_t` packed struct {r,g,b};
  - 640×480 timing constants and derived totals (`H_TOTAL`=800, `V_TOTAL`=525);
  - `FB_ADDR_W`=19 and `FB_PIXELS`=307200.
- Sub-module `vga_timing` holds:
  - the `h`/`v` counters;
  - sync decode;
  - active, frame-start and flip-point strobes.
- The top level holds the address counter, swap tracking, pipeline alignment and output registers.

## Test plan
- Reset release, 2 frames: `hsync` low for 96 cycles every 800 cycles; `vsync` low for 1600 cycles every 420000 cycles; 307200 `rd_en` cycles per frame.
- Memory model returning `rd_data`=`rd_addr[8:0]` with `RD_LATENCY`=1: pin value at active pixel k equals k[8:0]; `frame_start` coincides with pixel 0 on the pins; blank pins read 0.
- `swap` toggled at line 100: `front_bank` flips 1 cycle after `h=0,v=480`; the next frame's reads use `rd_bank`=1.
- `swap` toggled twice within one frame: exactly one flip. A toggle landing exactly on the flip-point cycle flips in the current frame.
- `rst_n` pulsed low at `h=300,v=200`: outputs take reset values asynchronously; scan restarts at pixel 0 with `rd_addr`=0.
- With `VGA_SCANOUT_BORDER_EN` defined and `rd_data`=0: pins read 9'h1FF at (0,0), (639,10) and (5,479), and 0 at (1,1).
